// File: rtl/aipp_boost_scheduler.sv
// aipp_boost_scheduler: round-robin VRM boost-rail sequencer shared by N_REQ AIPP parsers.
// Optional REQ-state ack timeout enabled by defining AIPP_ACK_TIMEOUT_EN.
module aipp_boost_scheduler #(
  parameter int N_REQ       = 4,
  parameter int LEAD_CYC    = 16,
  parameter int HOLD_CYC    = 64,
  parameter int COOL_CYC    = 32,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_trigger,
  output logic [N_REQ-1:0] req_grant,
  output logic             boost_req,
  input  logic             boost_ack,
  output logic             boost_active,
  output logic [N_REQ-1:0] gate_release,
  output logic             busy,
  output logic [2:0]       state_dbg,
  output logic [15:0]      drop_count,
  output logic             ack_timeout
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(N_REQ + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, LEAD = 3'd2, HOLD = 3'd3, COOL = 3'd4} state_t;
  state_t           state;
  logic [N_REQ-1:0] prev, pending, rise, clr, drop;
  logic [IW-1:0]    last_grant, grantee, sel;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    n_drop;
  logic [16:0]      drop_sum;
  always_comb begin
    int j;
    found = 1'b0;
    sel = '0;
    j = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last_grant) + k) % N_REQ;
      if (!found && pending[j]) begin
        found = 1'b1;
        sel = IW'(j);
      end
    end
  end
  assign rise = req_trigger & ~prev;
  assign clr  = (state == IDLE && found) ? N_REQ'(1) << sel : '0;
  assign drop = rise & pending & ~clr;
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_REQ; i++) n_drop = n_drop + DW'(drop[i]);
  end
  assign drop_sum = 17'(drop_count) + 17'(n_drop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev         <= '0;
      pending      <= '0;
      last_grant   <= IW'(N_REQ - 1);
      grantee      <= '0;
      cnt          <= '0;
      req_grant    <= '0;
      gate_release <= '0;
      drop_count   <= '0;
      ack_timeout  <= 1'b0;
    end else begin
      prev         <= req_trigger;
      pending      <= (pending & ~clr) | rise;
      drop_count   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      req_grant    <= clr;
      gate_release <= '0;
      ack_timeout  <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state      <= REQ;
          last_grant <= sel;
          grantee    <= sel;
          cnt        <= '0;
        end
        REQ: if (boost_ack) begin
          state <= LEAD;
          cnt   <= '0;
        end
`ifdef AIPP_ACK_TIMEOUT_EN
        else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state       <= COOL;
          cnt         <= '0;
          ack_timeout <= 1'b1;
        end else cnt <= cnt + CNT_W'(1);
`endif
        LEAD: if (cnt == CNT_W'(LEAD_CYC - 1)) begin
          state        <= HOLD;
          cnt          <= '0;
          gate_release <= N_REQ'(1) << grantee;
        end else cnt <= cnt + CNT_W'(1);
        HOLD: if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state <= COOL;
          cnt   <= '0;
        end else cnt <= cnt + CNT_W'(1);
        COOL: if (cnt == CNT_W'(COOL_CYC - 1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else cnt <= cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
  assign boost_req    = state == REQ || state == LEAD || state == HOLD;
  assign boost_active = state == HOLD;
  assign busy         = state != IDLE;
  assign state_dbg    = state;
endmodule

// File: tb/tb_aipp_boost_scheduler.sv
// tb_aipp_boost_scheduler: vector table plus grant scoreboard for aipp_boost_scheduler (default build).
module tb_aipp_boost_scheduler;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, boost_ack = 1'b0;
  logic [N-1:0] req_trigger = '0;
  logic [N-1:0] req_grant, gate_release;
  logic boost_req, boost_active, busy, ack_timeout;
  logic [2:0] state_dbg;
  logic [15:0] drop_count;
  int n_checks = 0, n_fail = 0;
  logic [N-1:0] sb[$];
  typedef struct {int lane; int stall; int exp_hold; int exp_idle;} vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  aipp_boost_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_trigger(req_trigger), .req_grant(req_grant),
    .boost_req(boost_req), .boost_ack(boost_ack), .boost_active(boost_active),
    .gate_release(gate_release), .busy(busy), .state_dbg(state_dbg),
    .drop_count(drop_count), .ack_timeout(ack_timeout)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // every grant pulse must match the oldest expected grant
  always @(negedge clk) begin
    if (req_grant !== '0) begin
      if (sb.size() == 0) check("unexpected_grant", longint'(req_grant), 0);
      else check("grant_order", longint'(req_grant), longint'(sb.pop_front()));
    end
  end

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk); req_trigger = req_trigger | m;
    @(negedge clk); req_trigger = req_trigger & ~m;
  endtask

  task automatic wait_grant(output int w);
    w = 0;
    while (req_grant == '0 && w < 400) begin
      @(negedge clk); w++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_seq(input int lane, input int stall, output int t_hold, output int t_idle,
                         output int n_act, output int t_gate, output int n_gate, output int ok);
    int k;
    k = 0; t_hold = -1; t_gate = -1; n_act = 0; n_gate = 0; ok = 1;
    while (busy && k < 600) begin
      if (state_dbg == 3'd1) boost_ack = (k >= stall);
      if (k > 0 && req_grant != '0) ok = 0;
      if (boost_req != (state_dbg == 3'd1 || state_dbg == 3'd2 || state_dbg == 3'd3)) ok = 0;
      if (boost_active) begin
        n_act++;
        if (t_hold < 0) t_hold = k;
      end
      if (gate_release != '0) begin
        n_gate++;
        t_gate = k;
        if (gate_release != (N'(1) << lane)) ok = 0;
      end
      @(negedge clk); k++;
    end
    t_idle = k;
    boost_ack = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int lane, input int stall, input int exp_hold, input int exp_idle);
    int th, ti, na, tg, ng, ok;
    run_seq(lane, stall, th, ti, na, tg, ng, ok);
    check({tag, "_hold_start"}, th, exp_hold);
    check({tag, "_active_len"}, na, 64);
    check({tag, "_gate_count"}, ng, 1);
    check({tag, "_gate_time"}, tg, exp_hold);
    check({tag, "_idle_time"}, ti, exp_idle);
    check({tag, "_shape_ok"}, ok, 1);
  endtask

  initial begin
    int w, th, ti, na, tg, ng, ok;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{lane: 2, stall: 0,  exp_hold: 17, exp_idle: 113};
    vecs[1] = '{lane: 0, stall: 10, exp_hold: 27, exp_idle: 123};
    vecs[2] = '{lane: 3, stall: 3,  exp_hold: 20, exp_idle: 116};
    vecs[3] = '{lane: 1, stall: 0,  exp_hold: 17, exp_idle: 113};
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_boost_req", boost_req, 0);
    check("reset_grant", req_grant, 0);
    check("reset_drop", drop_count, 0);
    check("reset_state", state_dbg, 0);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      sb.push_back(N'(1) << vecs[i].lane);
      pulse(N'(1) << vecs[i].lane);
      wait_grant(w);
      check($sformatf("vec%0d_grant_latency", i), w, 1);
      check($sformatf("vec%0d_req_state", i), state_dbg, 1);
      check_seq($sformatf("vec%0d", i), vecs[i].lane, vecs[i].stall, vecs[i].exp_hold, vecs[i].exp_idle);
    end
    // round-robin from a fresh reset: last_grant starts at N-1
    do_reset();
    sb.push_back(4'b0001); sb.push_back(4'b0010); sb.push_back(4'b1000);
    pulse(4'b1011);
    wait_grant(w);
    check("rr0_latency", w, 1);
    check_seq("rr0", 0, 0, 17, 113);
    wait_grant(w);
    check("rr1_gap", w, 1);
    check_seq("rr1", 1, 0, 17, 113);
    wait_grant(w);
    check("rr3_gap", w, 1);
    check_seq("rr3", 3, 0, 17, 113);
    sb.push_back(4'b0001);
    pulse(4'b0001);
    wait_grant(w);
    check("rr0b_latency", w, 1);
    check_seq("rr0b", 0, 0, 17, 113);
    check("rr_drop_zero", drop_count, 0);
    // three lane-1 rises while lane 0 is busy collapse into one grant
    sb.push_back(4'b0001);
    pulse(4'b0001);
    wait_grant(w);
    sb.push_back(4'b0010);
    fork
      check_seq("drop_l0", 0, 0, 17, 113);
      begin
        repeat (4) @(negedge clk);
        pulse(4'b0010); pulse(4'b0010); pulse(4'b0010);
      end
    join
    check("drop_count", drop_count, 2);
    wait_grant(w);
    check("drop_l1_gap", w, 1);
    check_seq("drop_l1", 1, 0, 17, 113);
    repeat (40) @(negedge clk);
    check("drop_no_regrant", busy, 0);
    // reset during HOLD cycle 20 with lane 3 pending
    sb.push_back(4'b0100);
    pulse(4'b0100);
    wait_grant(w);
    boost_ack = 1'b1;
    repeat (5) @(negedge clk);
    req_trigger[3] = 1'b1;
    @(negedge clk); req_trigger[3] = 1'b0;
    repeat (31) @(negedge clk);
    check("midhold_active", boost_active, 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    boost_ack = 1'b0;
    check("midhold_boost_req", boost_req, 0);
    check("midhold_boost_active", boost_active, 0);
    check("midhold_busy", busy, 0);
    check("midhold_state", state_dbg, 0);
    check("midhold_drop", drop_count, 0);
    repeat (30) @(negedge clk);
    check("midhold_pending_cleared", busy, 0);
    check("ack_timeout_low", ack_timeout, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aipp_boost_scheduler.md
Name: aipp_boost_scheduler

Overview:
- Shares one pre-voltage boost rail request between N_REQ AIPP header parsers.
- Each parser raises a level trigger on a heavy-job packet. This block latches each trigger rising edge as a pending request and arbitrates round-robin.
- It sequences the VRM handshake (request, ack, lead time, hold, cooldown) and tells the granted compute lane when the rail is boosted.
- Sits between the parser bank and the rail/VRM control interface.

Parameters:
- N_REQ, 4, number of requesting parsers (2..8).
- LEAD_CYC, 16, cycles between VRM ack and rail-ready (>=1).
- HOLD_CYC, 64, cycles boost held (>=1).
- COOL_CYC, 32, cycles between boost release and next grant (>=1).
- CNT_W, 8, width of phase counter; must hold max(LEAD_CYC,HOLD_CYC,COOL_CYC,ACK_TIMEOUT).
- ACK_TIMEOUT, 32, REQ-state wait limit; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous and active-low.
- req_trigger  in  N_REQ  per-parser level trigger.
- req_grant  out  N_REQ  one-hot, one-cycle grant pulse.
- boost_req  out  1  rail boost request to VRM.
- boost_ack  in  1  VRM acknowledge; level, sampled only in REQ.
- boost_active  out  1  high throughout HOLD.
- gate_release  out  N_REQ  one-cycle pulse to the granted lane on the first HOLD cycle.
- busy  out  1  state != IDLE.
- state_dbg  out  3  encoding IDLE=0, REQ=1, LEAD=2, HOLD=3, COOL=4.
- drop_count  out  16  saturating count of collapsed requests.
- ack_timeout  out  1  one-cycle timeout pulse; see Optional Feature.

Behaviour:
- Reset: when rst_n is sampled low at a clk edge, all outputs go to 0, state=IDLE, pending=0, edge-history=0, last_grant=N_REQ-1, counter=0. A reset mid-sequence aborts immediately; boost_req is low in the cycle after reset is sampled.
- Edge detect: rise[i] = req_trigger[i] & ~prev[i], with prev registered every cycle. Because prev resets to 0, a trigger held high across reset release counts as a rise.
- Pending: pending[i] is set on rise[i] and cleared when granted. If rise[i] arrives while pending[i] is already set and is not being cleared that cycle, drop_count increments, saturating at 0xFFFF. If rise[i] coincides with the grant of i, pending[i] stays set and no drop is counted.
- Arbitration (IDLE only): if any pending bit is set, pick the first set bit searching from last_grant+1 upward with wrap.
  - At that edge: state<=REQ, req_grant<=onehot for one cycle, pending bit cleared, last_grant updated, grantee index stored.
  - Triggers arriving in non-IDLE states stay pending.
- Outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- boost_req = 1 in REQ, LEAD and HOLD; 0 in IDLE and COOL.
- REQ: wait for boost_ack=1. Ack sampled high at an edge → LEAD with counter=0. Ack high in the first REQ cycle is legal and gives a 1-cycle REQ.
- LEAD: exactly LEAD_CYC cycles, then HOLD.
- HOLD: exactly HOLD_CYC cycles.
  - boost_active=1 for all of them.
  - gate_release[grantee]=1 on the first HOLD cycle only.
  - Then COOL.
- COOL: exactly COOL_CYC cycles, then IDLE. The next grant can occur at the edge ending the first IDLE cycle.
- Reference latency (defaults): rise detected at edge E → grant pulse visible after E+1 → with immediate ack, LEAD starts after E+2, HOLD starts after E+18, COOL after E+82, IDLE after E+114.
- boost_ack outside REQ is ignored.

Optional Feature:
- Macro: AIPP_ACK_TIMEOUT_EN.
- Defined: in REQ, the counter counts cycles without ack. After ACK_TIMEOUT cycles with no ack: pulse ack_timeout for one cycle and go to COOL, skipping HOLD so no gate_release is issued. The grant is consumed and not re-queued.
- Undefined: REQ waits indefinitely; ack_timeout is tied 0.

Test Plan:
- Single request: rise on req_trigger[2], ack tied 1 → req_grant=4'b0100 one cycle; boost_active high exactly 64 cycles starting 17 cycles after grant; gate_release[2] single pulse; busy low 113 cycles after grant.
- Round-robin: rises on lanes 0, 1 and 3 in the same cycle after reset → grants in order 0, 1, 3, each separated by a full 114-cycle sequence; then lane 0 again after re-trigger.
- Collapse/drop: lane 1 toggles 3 rises while busy with lane 0 → exactly one lane-1 grant; drop_count=2. Force 0xFFFF → remains 0xFFFF.
- Ack stall: ack held 0 for 10 REQ cycles, then 1 → boost_req high throughout; HOLD begins 16 cycles after ack.
- Reset mid-HOLD: rst_n low one cycle in HOLD cycle 20 → next cycle boost_req=0, boost_active=0, busy=0, pending cleared, drop_count=0.
- With AIPP_ACK_TIMEOUT_EN: ack never asserted → ack_timeout pulses after 32 REQ cycles; no boost_active or gate_release; IDLE 32 cycles later.
